// File: rtl/trng_word_packer_if.sv
// trng_word_packer_if
//   Groups the bit-stream input, the ready/valid word port and the
//   statistics signals of trng_word_packer.
//   master : the environment side (drives in_valid, in_bit, word_ready, clear_stats)
//   slave  : the packer side (drives word_valid, word_data, fifo_count,
//            overflow, drop_count)
//   Parameters must match those of the connected trng_word_packer.
interface trng_word_packer_if #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic              in_bit;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              clear_stats;

  modport master (
    output in_valid, in_bit, word_ready, clear_stats,
    input  word_valid, word_data, fifo_count, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_bit, word_ready, clear_stats,
    output word_valid, word_data, fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/trng_word_packer.sv
// trng_word_packer
//   Packs the debiased one-bit trng stream into WORD_W-bit words (bit 0 is
//   the first bit received), buffers completed words in a show-ahead FIFO
//   and presents them on a ready/valid port. Words completing while the FIFO
//   is full are dropped and counted. The input side never stalls.
//   Ports:
//     clk   : clock, all state updates on its rising edge
//     reset : asynchronous, active-low reset (asserted at 0)
//     bus   : trng_word_packer_if.slave (bit input, word port, statistics)
module trng_word_packer #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input logic              clk,
  input logic              reset,
  trng_word_packer_if.slave bus
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] dropCnt_q, dropCnt_d;

  logic wordDone;
  logic pop;
  logic slotFree;
  logic push;
  logic drop;

  always_comb begin
    acc_d      = acc_q;
    idx_d      = idx_q;
    wordDone   = 1'b0;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;

    // acc_d doubles as the completed word on the final bit, so the word
    // pushed into the FIFO already carries in_bit in its top position.
    if (bus.in_valid) begin
      acc_d[idx_q] = bus.in_bit;
      wordDone     = (idx_q == IDX_W'(WORD_W - 1));
      idx_d        = wordDone ? '0 : idx_q + 1'b1;
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    pop      = (count_q != '0) && bus.word_ready;
    slotFree = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
    push     = wordDone && slotFree;
    drop     = wordDone && !slotFree;

    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear wins: the counter restarts at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clear_stats)
        dropCnt_d = DROP_W'(1);
      else if (dropCnt_q != '1)
        dropCnt_d = dropCnt_q + 1'b1;
    end else if (bus.clear_stats) begin
      overflow_d = 1'b0;
      dropCnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      idx_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
      if (push) mem_q[wrPtr_q] <= acc_d;
    end
  end

  // word_data is forced to zero while empty so it reads zero out of reset.
  assign bus.word_valid = (count_q != '0);
  assign bus.word_data  = (count_q != '0) ? mem_q[rdPtr_q] : '0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = dropCnt_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// tb_trng_word_packer
//   Directed testbench for trng_word_packer with WORD_W=8, FIFO_DEPTH=2,
//   DROP_W=4. Inputs change 1 ns after each rising edge and outputs are
//   sampled at that same point, away from the active edge.
module tb_trng_word_packer;
  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int DROP_W     = 4;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  trng_word_packer_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)) bus ();

  trng_word_packer #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one input bit (or an idle cycle) and advances past the next edge.
  task automatic applyStimulus(input logic valid, input logic bitVal);
    bus.in_valid = valid;
    bus.in_bit   = bitVal;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 0; i < WORD_W; i++) applyStimulus(1'b1, w[i]);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0);
  endtask

  logic [7:0] pattern;

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    reset            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_bit       = 1'b0;
    bus.word_ready   = 1'b0;
    bus.clear_stats  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("rst_data", 32'(bus.word_data), 32'h00);
    checkOutput("rst_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_drops", 32'(bus.drop_count), 32'd0);
    reset = 1'b1;
    idle();

    // Basic pack: bits 1,0,1,1,0,0,0,1 -> 8'h8D
    $display("[TB] basic pack");
    pattern        = 8'h8D;
    bus.word_ready = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, pattern[i]);
    checkOutput("basic_not_yet", 32'(bus.word_valid), 32'd0);
    applyStimulus(1'b1, pattern[7]);
    checkOutput("basic_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("basic_data", 32'(bus.word_data), 32'h8D);
    checkOutput("basic_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    checkOutput("basic_popped", 32'(bus.word_valid), 32'd0);
    checkOutput("basic_count0", 32'(bus.fifo_count), 32'd0);

    // Gapped input: invalid cycles carry the complement bit, which must be ignored
    $display("[TB] gapped input");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, pattern[i]);
      if (i == 6) checkOutput("gap_not_yet", 32'(bus.word_valid), 32'd0);
      if (i < 7) applyStimulus(1'b0, ~pattern[i]);
    end
    checkOutput("gap_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("gap_data", 32'(bus.word_data), 32'h8D);
    idle();
    checkOutput("gap_popped", 32'(bus.fifo_count), 32'd0);

    // Backpressure and overflow
    $display("[TB] backpressure and overflow");
    bus.word_ready = 1'b0;
    sendWord(8'h01);
    sendWord(8'h02);
    checkOutput("bp_no_overflow", 32'(bus.overflow), 32'd0);
    sendWord(8'h03);
    checkOutput("bp_count", 32'(bus.fifo_count), 32'd2);
    checkOutput("bp_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("bp_drops", 32'(bus.drop_count), 32'd1);
    checkOutput("bp_head", 32'(bus.word_data), 32'h01);
    bus.word_ready = 1'b1;
    idle();
    checkOutput("bp_second", 32'(bus.word_data), 32'h02);
    checkOutput("bp_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    checkOutput("bp_empty", 32'(bus.word_valid), 32'd0);

    // Full FIFO with simultaneous push and pop
    $display("[TB] full with push and pop");
    bus.word_ready = 1'b0;
    sendWord(8'hAA);
    sendWord(8'hBB);
    pattern = 8'hCC;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, pattern[i]);
    bus.word_ready = 1'b1;
    applyStimulus(1'b1, pattern[7]);
    bus.word_ready = 1'b0;
    checkOutput("pp_count", 32'(bus.fifo_count), 32'd2);
    checkOutput("pp_drops", 32'(bus.drop_count), 32'd1);
    checkOutput("pp_head", 32'(bus.word_data), 32'hBB);
    idle();
    checkOutput("pp_hold", 32'(bus.word_data), 32'hBB);
    bus.word_ready = 1'b1;
    idle();
    checkOutput("pp_next", 32'(bus.word_data), 32'hCC);
    idle();
    checkOutput("pp_empty", 32'(bus.fifo_count), 32'd0);

    // Saturation and clear: 1 earlier drop + 20 more saturates at 4'hF
    $display("[TB] saturation and clear");
    bus.word_ready = 1'b0;
    sendWord(8'h11);
    sendWord(8'h22);
    for (int w = 0; w < 20; w++) sendWord(8'h33);
    checkOutput("sat_drops", 32'(bus.drop_count), 32'hF);
    checkOutput("sat_overflow", 32'(bus.overflow), 32'd1);
    bus.clear_stats = 1'b1;
    idle();
    bus.clear_stats = 1'b0;
    checkOutput("clr_drops", 32'(bus.drop_count), 32'd0);
    checkOutput("clr_overflow", 32'(bus.overflow), 32'd0);
    pattern = 8'h44;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, pattern[i]);
    bus.clear_stats = 1'b1;
    applyStimulus(1'b1, pattern[7]);
    bus.clear_stats = 1'b0;
    checkOutput("clrdrop_drops", 32'(bus.drop_count), 32'd1);
    checkOutput("clrdrop_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("clrdrop_head", 32'(bus.word_data), 32'h11);

    // Reset mid-operation: one word buffered plus 5 bits of the next
    $display("[TB] reset mid-operation");
    bus.word_ready = 1'b1;
    idle();
    idle();
    bus.word_ready = 1'b0;
    sendWord(8'h5A);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_rst_count", 32'(bus.fifo_count), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(bus.word_valid), 32'd0);
    checkOutput("arst_data", 32'(bus.word_data), 32'h00);
    checkOutput("arst_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("arst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("arst_drops", 32'(bus.drop_count), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("post_rst_not_yet", 32'(bus.word_valid), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_rst_valid", 32'(bus.word_valid), 32'd1);
    checkOutput("post_rst_data", 32'(bus.word_data), 32'hFF);
    checkOutput("post_rst_count", 32'(bus.fifo_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
